// File: rtl/serial_port_router_if.sv
// Serial-frame router bundle: bit-rate enable, serial input and per-port enables in; routed payload and status out.
// Latency: pure wiring, no storage.
// Backpressure: none; the sink samples on enabled clock edges and cannot stall the link.
interface serial_port_router_if #(
   parameter int PORT_W = 2,
   parameter int LEN_W  = 4
);
   localparam int NP = 2**PORT_W;

   logic              clk_en;
   logic              ser_in;
   logic [NP-1:0]     port_en;
   logic              ser_out;
   logic [NP-1:0]     out_valid;
   logic [PORT_W-1:0] port_q;
   logic [LEN_W-1:0]  len_q;
   logic              busy;
   logic              done;
   logic              drop;

   // Router side
   modport slave (
      input  clk_en, ser_in, port_en,
      output ser_out, out_valid, port_q, len_q, busy, done, drop
   );

   // Serial source / sink side
   modport master (
      output clk_en, ser_in, port_en,
      input  ser_out, out_valid, port_q, len_q, busy, done, drop
   );
endinterface

// File: rtl/serial_port_router.sv
// Serial frame demux: start bit, port field, length field, payload routed to one of 2**PORT_W ports.
// Latency: payload bit k appears combinationally on ser_out in the k-th enabled DATA cycle; DONE follows the last bit.
// Backpressure: none; all state advances only on clk_en, disabled ports drop payload silently and flag it in DONE.
module serial_port_router #(
   parameter int PORT_W = 2,
   parameter int LEN_W  = 4
) (
   input logic              clk,
   input logic              rst,
   serial_port_router_if.slave bus
);
   localparam int NP    = 2**PORT_W;
   localparam int CNT_W = (PORT_W > LEN_W) ? PORT_W : LEN_W;

   typedef enum logic [2:0] {IDLE, PORT, LEN, DATA, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [LEN_W-1:0]  down_cnt;
   logic [PORT_W-1:0] port_reg;
   logic [LEN_W-1:0]  len_reg;
   logic              drop_reg;

   logic [PORT_W-1:0] port_shift;
   logic [LEN_W-1:0]  len_shift;
   logic              port_last;
   logic              len_last;

   // Fields arrive MSB first, so each new bit enters at the LSB end.
   assign port_shift = (port_reg << 1) | PORT_W'(bus.ser_in);
   assign len_shift  = (len_reg << 1) | LEN_W'(bus.ser_in);
   assign port_last  = (bit_cnt == CNT_W'(PORT_W - 1));
   assign len_last   = (bit_cnt == CNT_W'(LEN_W - 1));

   // State register; only enabled edges move the FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else if (bus.clk_en)
         state <= state_nxt;
   end

   // Next-state decode; the length test uses the fully shifted field so a zero-length frame skips DATA.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!bus.ser_in) state_nxt = PORT;
         PORT: if (port_last) state_nxt = LEN;
         LEN:  if (len_last) state_nxt = (len_shift == '0) ? DONE : DATA;
         DATA: if (down_cnt == LEN_W'(1)) state_nxt = DONE;
         DONE: state_nxt = bus.ser_in ? IDLE : PORT;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: field shifters, bit counter, payload down-counter and the drop flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt  <= '0;
         down_cnt <= '0;
         port_reg <= '0;
         len_reg  <= '0;
         drop_reg <= 1'b0;
      end else if (bus.clk_en) begin
         case (state)
            IDLE, DONE: begin
               bit_cnt <= '0;
               // A new frame starts with a clean drop flag; the old value stays visible until then.
               if (state_nxt == PORT)
                  drop_reg <= 1'b0;
            end
            PORT: begin
               port_reg <= port_shift;
               bit_cnt  <= port_last ? '0 : bit_cnt + CNT_W'(1);
            end
            LEN: begin
               len_reg <= len_shift;
               if (len_last) begin
                  bit_cnt  <= '0;
                  // The enable is frozen here so port_en changes during DATA cannot affect this frame.
                  drop_reg <= ~bus.port_en[port_reg];
                  down_cnt <= len_shift;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            DATA: down_cnt <= down_cnt - LEN_W'(1);
            default: ;
         endcase
      end
   end

   // Moore output decodes; ser_out is a gated pass-through of the line during DATA.
   assign bus.ser_out   = (state == DATA) ? bus.ser_in : 1'b0;
   assign bus.out_valid = (state == DATA && !drop_reg) ? (NP'(1) << port_reg) : '0;
   assign bus.port_q    = port_reg;
   assign bus.len_q     = len_reg;
   assign bus.busy      = (state == PORT) || (state == LEN) || (state == DATA);
   assign bus.done      = (state == DONE);
   assign bus.drop      = (state == DONE) && drop_reg;
endmodule

// File: tb/tb_serial_port_router.sv
// Bench for serial_port_router: two instances (2/4 and 3/5 field widths) driven from a per-cycle expectation queue.
// Latency: each queue entry is one enabled cycle; disabled cycles in between must leave outputs unchanged.
// Backpressure: none; clk_en patterns (every cycle, every 3rd, random) emulate the bit-rate enable.
module tb_serial_port_router;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_port_router_if #(.PORT_W(2), .LEN_W(4)) bus_a ();
   serial_port_router_if #(.PORT_W(3), .LEN_W(5)) bus_b ();

   serial_port_router #(.PORT_W(2), .LEN_W(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   serial_port_router #(.PORT_W(3), .LEN_W(5)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   // Expected behaviour of one enabled cycle, built frame by frame from the framing rules.
   typedef struct {
      logic       ser;
      logic [7:0] pen;
      logic       busy;
      logic       done;
      logic       drop;
      logic       sout;
      logic [7:0] valid;
      logic       chk_q;
      logic [2:0] pq;
      logic [4:0] lq;
   } cyc_t;

   cyc_t q[$];
   int   sel = 0;
   int   pw  = 2;
   int   lw  = 4;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc_idx = 0;

   logic [7:0] o_valid, o_pq, o_lq;
   logic       o_busy, o_done, o_drop, o_sout;

   // Observe whichever instance is under test, widened to common widths.
   always_comb begin
      if (sel == 0) begin
         o_valid = 8'(bus_a.out_valid);
         o_pq    = 8'(bus_a.port_q);
         o_lq    = 8'(bus_a.len_q);
         o_busy  = bus_a.busy;
         o_done  = bus_a.done;
         o_drop  = bus_a.drop;
         o_sout  = bus_a.ser_out;
      end else begin
         o_valid = bus_b.out_valid;
         o_pq    = 8'(bus_b.port_q);
         o_lq    = 8'(bus_b.len_q);
         o_busy  = bus_b.busy;
         o_done  = bus_b.done;
         o_drop  = bus_b.drop;
         o_sout  = bus_b.ser_out;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_idx, got, exp);
      end
   endtask

   task automatic set_in(input logic ser, input logic [7:0] pen, input logic en);
      if (sel == 0) begin
         bus_a.ser_in  = ser;
         bus_a.port_en = pen[3:0];
         bus_a.clk_en  = en;
         bus_b.ser_in  = 1'b1;
         bus_b.port_en = '1;
         bus_b.clk_en  = 1'b0;
      end else begin
         bus_b.ser_in  = ser;
         bus_b.port_en = pen;
         bus_b.clk_en  = en;
         bus_a.ser_in  = 1'b1;
         bus_a.port_en = '1;
         bus_a.clk_en  = 1'b0;
      end
   endtask

   function automatic cyc_t blank(input logic [7:0] mask);
      cyc_t c;
      c.ser = 1'b1; c.pen = mask; c.busy = 1'b0; c.done = 1'b0; c.drop = 1'b0;
      c.sout = 1'b0; c.valid = '0; c.chk_q = 1'b0; c.pq = '0; c.lq = '0;
      return c;
   endfunction

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) q.push_back(blank(8'hFF));
   endtask

   // Payload is given MSB first: bit k of the payload is data[len-1-k].
   task automatic add_frame(input int port, input int len, input logic [31:0] data,
                            input logic [7:0] mask, input bit b2b);
      cyc_t c;
      if (b2b && q.size() > 0) begin
         q[q.size()-1].ser = 1'b0;   // start bit rides on the previous DONE cycle
      end else begin
         c = blank(mask); c.ser = 1'b0; q.push_back(c);
      end
      for (int i = pw - 1; i >= 0; i--) begin
         c = blank(mask); c.ser = port[i]; c.busy = 1'b1; q.push_back(c);
      end
      for (int i = lw - 1; i >= 0; i--) begin
         c = blank(mask); c.ser = len[i]; c.busy = 1'b1; q.push_back(c);
      end
      for (int k = 0; k < len; k++) begin
         c = blank(8'($urandom));       // enable changes mid-payload must not matter
         c.ser   = data[len-1-k];
         c.busy  = 1'b1;
         c.sout  = c.ser;
         c.valid = mask[port] ? (8'd1 << port) : 8'd0;
         q.push_back(c);
      end
      c = blank(mask);
      c.done = 1'b1; c.drop = ~mask[port];
      c.chk_q = 1'b1; c.pq = 3'(port); c.lq = 5'(len);
      q.push_back(c);
   endtask

   // mode 0: enable every cycle, 1: every 3rd cycle, 2: random gaps.
   task automatic run_q(input int mode);
      cyc_t c;
      int gap;
      while (q.size() > 0) begin
         c = q.pop_front();
         gap = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g <= gap; g++) begin
            set_in(c.ser, c.pen, g == gap);
            @(negedge clk);
            check("busy", 32'(o_busy), 32'(c.busy));
            check("done", 32'(o_done), 32'(c.done));
            check("drop", 32'(o_drop), 32'(c.drop));
            check("ser_out", 32'(o_sout), 32'(c.sout));
            check("out_valid", 32'(o_valid), 32'(c.valid));
            if (c.chk_q) begin
               check("port_q", 32'(o_pq), 32'(c.pq));
               check("len_q", 32'(o_lq), 32'(c.lq));
            end
            @(posedge clk); #1;
         end
         cyc_idx++;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  32'(o_busy),  0);
      check({tag, "_done"},  32'(o_done),  0);
      check({tag, "_drop"},  32'(o_drop),  0);
      check({tag, "_sout"},  32'(o_sout),  0);
      check({tag, "_valid"}, 32'(o_valid), 0);
      check({tag, "_pq"},    32'(o_pq),    0);
      check({tag, "_lq"},    32'(o_lq),    0);
   endtask

   initial begin
      logic [4:0] hdr;
      int port, len;
      rst = 1'b1;
      sel = 0;
      set_in(1'b1, 8'hFF, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Abort a frame in LEN: start, port=2, two length bits, then reset.
      hdr = 5'b01001;
      for (int i = 4; i >= 0; i--) begin
         set_in(hdr[i], 8'hFF, 1'b1);
         @(posedge clk); #1;
      end
      set_in(1'b1, 8'hFF, 1'b0);
      @(negedge clk);
      check("mid_len_busy", 32'(o_busy), 1);
      check("mid_len_pq", 32'(o_pq), 2);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("abort");
      @(posedge clk); #1;
      rst = 1'b0;

      // Clean frame after abort, then the directed cases.
      add_frame(2, 5, 32'b10110, 8'h0F, 0); add_idle(2); run_q(0);
      add_frame(3, 0, 32'h0, 8'h0F, 0); add_idle(1); run_q(0);
      add_frame(1, 3, 32'b101, 8'h0D, 0); add_idle(1);
      add_frame(0, 2, 32'b11, 8'h0D, 0); add_idle(1); run_q(0);
      add_frame(1, 3, 32'b011, 8'h0F, 0);
      add_frame(0, 2, 32'b11, 8'h0F, 1); add_idle(2); run_q(0);
      add_frame(2, 5, 32'b10110, 8'h0F, 0); add_idle(1); run_q(1);

      // Random frames on the narrow instance.
      for (int f = 0; f < 20; f++) begin
         port = int'($urandom_range(0, 3));
         len  = int'($urandom_range(0, 15));
         add_frame(port, len, $urandom, 8'($urandom_range(0, 15)), (f > 0) && ($urandom_range(0, 1) == 1));
         if ($urandom_range(0, 2) == 0) add_idle(int'($urandom_range(1, 3)));
      end
      add_idle(1); run_q(2);

      // Wide instance: port 6, 17-bit payload at one-third bit rate, then random frames.
      sel = 1; pw = 3; lw = 5;
      set_in(1'b1, 8'hFF, 1'b0);
      @(posedge clk); #1;
      add_frame(6, 17, $urandom, 8'hFF, 0); add_idle(1); run_q(1);
      for (int f = 0; f < 12; f++) begin
         port = int'($urandom_range(0, 7));
         len  = int'($urandom_range(0, 31));
         add_frame(port, len, $urandom, 8'($urandom), (f > 0) && ($urandom_range(0, 1) == 1));
         if ($urandom_range(0, 2) == 0) add_idle(int'($urandom_range(1, 3)));
      end
      add_idle(1); run_q(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end
endmodule

// File: doc/serial_port_router.md
# serial_port_router

Parametrised serial frame demultiplexer. It receives one serial bit per enabled clock on `ser_in`, decodes a frame of start bit, port field, length field and payload, and routes the payload to one of `2**PORT_W` output ports with a one-hot valid. It adds three things to the fixed-width controller used by the serial link:

- an integrated datapath (shift registers and counters);
- a per-port enable with drop reporting;
- zero-length frame handling.

It sits behind the baud-rate clock-enable generator and ahead of the per-port sinks.

## Interface
Parameters:
- `PORT_W`, default 2: width of the port field; number of ports `NP = 2**PORT_W`.
- `LEN_W`, default 4: width of the length field; payload length 0 to `2**LEN_W-1` bits.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `clk_en`  in  1  bit-rate enable; all state advances only when high
- `ser_in`  in  1  serial input, idle-high, MSB first within fields
- `port_en`  in  `NP`  per-port enable, sampled when the frame leaves LEN
- `ser_out`  out  1  payload data; equals `ser_in` while in DATA, else 0
- `out_valid`  out  `NP`  one-hot valid for the selected port during DATA, when that port is enabled
- `port_q`  out  `PORT_W`  latched port of the current/last frame
- `len_q`  out  `LEN_W`  latched length of the current/last frame
- `busy`  out  1  high in PORT, LEN, DATA
- `done`  out  1  high in DONE
- `drop`  out  1  high in DONE if the frame's port was disabled

## Operation
States: IDLE, PORT, LEN, DATA, DONE. All transitions happen on `clk` rising edges with `clk_en`=1 only; with `clk_en`=0, state, counters and registers hold.

- **IDLE:** `ser_in`=0 → PORT; else stay.
- **PORT:** shift `ser_in` into the port register, MSB first; bit counter counts 0..`PORT_W-1`. After the `PORT_W`-th bit → LEN.
- **LEN:** shift `ser_in` into the length register; bit counter counts 0..`LEN_W-1`. After the `LEN_W`-th bit:
  - latch `port_en[port_q]` into the drop flag (inverted);
  - load the down-counter with the length;
  - if length=0 → DONE, else → DATA.
- **DATA:** each enabled cycle consumes one payload bit and decrements the counter. When the counter reaches 1 and that bit is consumed → DONE.
  - `ser_out` = `ser_in` (combinational).
  - `out_valid[port_q]` = 1 unless dropped; all other bits 0.
  - If dropped, `out_valid` is all-zero but the bits are still consumed.
- **DONE:** `done`=1, and `drop` = drop flag. `ser_in`=0 → PORT (back-to-back frame, this bit is its start bit); else → IDLE.

Output and register rules:
- Outputs are Moore decodes of state and registers.
- `port_q` and `len_q` hold their values until overwritten by the next frame's shifting.
- The drop flag clears on entry to PORT.

## Timing
- Reset: state IDLE; counters, `port_q`, `len_q` and the drop flag are 0. `ser_out`, `out_valid`, `busy`, `done` and `drop` are all 0.
- Reset mid-frame aborts immediately. No `done` is produced for the aborted frame.
- Frame length in enabled cycles: 1 (start) + `PORT_W` + `LEN_W` + L + 1 (DONE).
- Payload bit k (0-based) is valid during the k-th enabled cycle in DATA.
- Sinks sample `ser_out`/`out_valid` only on `clk` edges with `clk_en`=1. Outputs stay static across `clk_en`=0 cycles.
- `port_en` changes during DATA have no effect on the current frame.
- Counter width is `max(PORT_W, LEN_W)` for the bit counter and `LEN_W` for the down-counter. No wrap-around is reachable.
- `done` lasts exactly one enabled cycle (plus any intervening disabled cycles).

## Test plan
Default parameters (`PORT_W`=2, `LEN_W`=4), `port_en`=4'b1111, `clk_en` every cycle unless stated.

1. Reset during LEN → all outputs 0 and state IDLE. A subsequent clean frame works.
2. Frame port=2, len=5, data 10110 → `out_valid`=4'b0100 for exactly 5 cycles, `ser_out`=1,0,1,1,0. Then `done`=1 for 1 cycle, `drop`=0, `port_q`=2, `len_q`=5.
3. Port=3, len=0 → no DATA cycles and `out_valid` never set. `done` follows LEN directly; the frame totals 8 cycles.
4. `port_en`=4'b1101, frame port=1, len=3 → `out_valid` stays 0 for 3 DATA cycles, then `done`=1 with `drop`=1. The next frame to port 0 gives `drop`=0.
5. Back-to-back: `ser_in`=0 during DONE → PORT on the next cycle with no IDLE. The second frame (port=0, len=2, data 11) routes to `out_valid`=4'b0001.
6. `clk_en` high every 3rd cycle for test 2's frame → identical bit sequence and valid count; state changes only on enabled edges. Repeat with `PORT_W`=3, `LEN_W`=5, port=6, len=17 → `out_valid[6]` high for 17 enabled cycles.
